// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit
// ----------------------------------------------------------------------------
// Instruction fetch stage sitting directly upstream of the CPU control unit.
// Owns the program counter, issues instruction reads on the shared bus, and
// latches the returned word into the instruction register (IR) that feeds
// decode/execute.
//
// A fetch ("launch") is started by:
//   - leaving BOOT after reset,
//   - the control unit's one-cycle i_start_fetch pulse while in HOLD,
//   - a trap/return redirect (i_trap_fetch), from any state.
// Bus timeouts and misaligned fetch addresses are reported to the trap logic
// through two sticky flags that only a trap redirect (or reset) clears.
//
// Parameters
//   RESET_PC        PC value loaded by reset; target of the first fetch
//   TIMEOUT_CYCLES  cycles in WAIT without i_bus_DV before a fault; 0 = never
//
// Ports
//   i_clk           clock, all state changes on the rising edge
//   i_rst           synchronous active-high reset
//   i_start_fetch   control unit pulse: fetch at the current PC (HOLD only)
//   i_load_PC       control unit: PC <= i_next_pc (HOLD only)
//   i_next_pc       sequential/branch target from execute
//   i_trap_fetch    pulse: PC <= i_trap_pc and start a fetch (any state)
//   i_trap_pc       trap vector or return address
//   i_bus_DV        bus read data valid (shared with load/store)
//   i_bus_rdata     bus read data
//   o_bus_req       instruction read request, held high until data valid
//   o_bus_addr      read address, equals o_pc
//   o_pc            current PC
//   o_ir            fetched instruction word
//   o_ir_valid      o_ir holds the word fetched from o_pc
//   o_fetch_fault   sticky: bus timeout during fetch
//   o_misaligned    sticky: fetch attempted with PC[1:0] != 0
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start_fetch,
    input  logic        i_load_PC,
    input  logic [31:0] i_next_pc,
    input  logic        i_trap_fetch,
    input  logic [31:0] i_trap_pc,
    input  logic        i_bus_DV,
    input  logic [31:0] i_bus_rdata,
    output logic        o_bus_req,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_pc,
    output logic [31:0] o_ir,
    output logic        o_ir_valid,
    output logic        o_fetch_fault,
    output logic        o_misaligned
);

    // The counter must be able to hold TIMEOUT_CYCLES; a disabled timeout
    // still gets a 1-bit counter so no zero-width vector is ever declared.
    localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    // Value of the counter in the last permitted WAIT cycle. Only consulted
    // when TIMEOUT_EN is set, so the wrapped value for 0 is never used.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,   // one idle cycle after reset, then first fetch
        S_WAIT  = 2'd1,   // request outstanding on the bus
        S_HOLD  = 2'd2,   // IR stable, waiting for the control unit
        S_FAULT = 2'd3    // parked after timeout/misalignment until a trap
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t           r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_ir;
    logic             r_ir_valid;
    logic             r_fetch_fault;
    logic             r_misaligned;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_state_nxt;
    logic [31:0]      w_pc_nxt;
    logic [31:0]      w_ir_nxt;
    logic             w_ir_valid_nxt;
    logic             w_fetch_fault_nxt;
    logic             w_misaligned_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_launch;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case statement can leave one unassigned and infer a latch.
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_ir_nxt          = r_ir;
        w_ir_valid_nxt    = r_ir_valid;
        w_fetch_fault_nxt = r_fetch_fault;
        w_misaligned_nxt  = r_misaligned;
        w_cnt_nxt         = r_cnt;
        w_launch          = 1'b0;

        if (i_trap_fetch) begin
            // A redirect wins over everything and abandons any request still
            // outstanding; it also acknowledges both sticky faults.
            w_pc_nxt          = i_trap_pc;
            w_fetch_fault_nxt = 1'b0;
            w_misaligned_nxt  = 1'b0;
            w_launch          = 1'b1;
        end else begin
            unique case (r_state)
                S_BOOT: begin
                    w_launch = 1'b1;
                end

                S_WAIT: begin
                    if (i_bus_DV) begin
                        w_ir_nxt       = i_bus_rdata;
                        w_ir_valid_nxt = 1'b1;
                        w_state_nxt    = S_HOLD;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        if (TIMEOUT_EN && (r_cnt == CNT_LAST)) begin
                            w_fetch_fault_nxt = 1'b1;
                            w_state_nxt       = S_FAULT;
                        end
                    end
                end

                S_HOLD: begin
                    // Bus data valid here belongs to load/store and is ignored.
                    if (i_load_PC) begin
                        w_pc_nxt = i_next_pc;
                    end
                    if (i_start_fetch) begin
                        w_launch = 1'b1;
                    end
                end

                S_FAULT: begin
                    // Parked: only a redirect (above) or reset leaves.
                end

                default: begin
                    w_state_nxt = S_BOOT;
                end
            endcase
        end

        // Launch is checked against w_pc_nxt, so a same-edge PC load or trap
        // target is the address actually fetched (bypass, not the old PC).
        if (w_launch) begin
            w_ir_valid_nxt = 1'b0;
            w_cnt_nxt      = '0;
            if (w_pc_nxt[1:0] != 2'b00) begin
                w_misaligned_nxt = 1'b1;
                w_state_nxt      = S_FAULT;
            end else begin
                w_state_nxt = S_WAIT;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: reset is sampled only on the clock edge (synchronous), so a
        // reset asserted mid-WAIT drops the request at the following edge.
        if (i_rst) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_ir          <= '0;
            r_ir_valid    <= 1'b0;
            r_fetch_fault <= 1'b0;
            r_misaligned  <= 1'b0;
            r_cnt         <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating
            // from the pre-edge values, independent of statement order.
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_ir          <= w_ir_nxt;
            r_ir_valid    <= w_ir_valid_nxt;
            r_fetch_fault <= w_fetch_fault_nxt;
            r_misaligned  <= w_misaligned_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_bus_req     = (r_state == S_WAIT);
    assign o_bus_addr    = r_pc;
    assign o_pc          = r_pc;
    assign o_ir          = r_ir;
    assign o_ir_valid    = r_ir_valid;
    assign o_fetch_fault = r_fetch_fault;
    assign o_misaligned  = r_misaligned;

endmodule
